password_fsm: RTL and testbench

//   Password-entry sequencer feeding the LED/7-segment display stage.

---
 rtl/password_pkg.sv | 29 ++
 rtl/password_fsm_if.sv | 24 ++
 rtl/key_debounce.sv | 67 ++++++
 rtl/password_fsm.sv | 114 +++++++++++
 tb/tb_password_fsm.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/password_pkg.sv
// Shared definitions for the password-entry sequencer and the display stage
// that decodes its 4-bit state code.
package password_pkg;

    // State codes as seen by the display stage.
    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_DIGIT_2 = 4'd1;
    localparam logic [3:0] ST_DIGIT_3 = 4'd2;
    localparam logic [3:0] ST_DIGIT_4 = 4'd3;
    localparam logic [3:0] ST_DONE    = 4'd4;
    localparam logic [3:0] ST_ERROR   = 4'd5;

    // FSM state type; encodings equal the display codes so the register
    // can drive the display output directly.
    typedef enum logic [3:0] {
        FSM_IDLE    = ST_IDLE,
        FSM_DIGIT_2 = ST_DIGIT_2,
        FSM_DIGIT_3 = ST_DIGIT_3,
        FSM_DIGIT_4 = ST_DIGIT_4,
        FSM_DONE    = ST_DONE,
        FSM_ERROR   = ST_ERROR
    } fsm_state_e;

    // Select one password nibble; idx 3 is the first digit entered.
    function automatic logic [3:0] pw_nibble(input logic [15:0] pw, input logic [1:0] idx);
        return pw[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/password_fsm_if.sv
// Signal bundle between the keypad/switch side and the password sequencer.
// Handshake: none. enter_btn and digit_in are raw asynchronous levels; the
// sequencer conditions them itself. enter_pulse is a one-cycle strobe per
// accepted press and state is a registered level, both synchronous to clk.
interface password_fsm_if;
    logic [3:0] digit_in;
    logic       enter_btn;
    logic [3:0] state;
    logic       enter_pulse;

    modport master (
        output digit_in,
        output enter_btn,
        input  state,
        input  enter_pulse
    );

    modport slave (
        input  digit_in,
        input  enter_btn,
        output state,
        output enter_pulse
    );
endinterface

// File: rtl/key_debounce.sv
// Button conditioning: 2-FF synchronizer, level debouncer and rising-edge
// strobe. The strobe appears the cycle after the debounced level rises.
module key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw_i,
    output logic pulse_o,
    output logic pulse_next_o
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          level_prev_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          pulse_q;
    logic          pulse_d;

    // Count consecutive samples that disagree with the debounced level; flip
    // the level once DEB_CYCLES of them have been seen. Any agreeing sample
    // restarts the count, so short bounces never get through.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q >= CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        pulse_d = level_q & ~level_prev_q;
    end

    // Synchronizer, debounce state and edge strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
            pulse_q      <= 1'b0;
        end else begin
            sync1_q      <= btn_raw_i;
            sync2_q      <= sync1_q;
            level_q      <= level_d;
            level_prev_q <= level_q;
            cnt_q        <= cnt_d;
            pulse_q      <= pulse_d;
        end
    end

    assign pulse_o      = pulse_q;
    // High in the cycle before pulse_o; lets the parent capture data in step
    // with the strobe.
    assign pulse_next_o = pulse_d;

endmodule

// File: rtl/password_fsm.sv
// Password-entry sequencer: conditions the enter button and digit switches,
// walks through the four password digits and reports progress as a 4-bit
// state code for the display stage.
module password_fsm
    import password_pkg::*;
#(
    parameter logic [15:0] PASSWORD   = 16'h2013,
    parameter int          DEB_CYCLES = 500000,
    parameter int          ERR_HOLD   = 50000000
) (
    input  logic          clk,
    input  logic          rst,
    password_fsm_if.slave bus
);

    localparam int TW = (ERR_HOLD > 1) ? $clog2(ERR_HOLD + 1) : 1;
    localparam logic [TW-1:0] ERR_LAST = TW'(ERR_HOLD - 1);

    logic          pulse;
    logic          pulse_next;
    logic [3:0]    dsync1_q;
    logic [3:0]    dsync2_q;
    logic [3:0]    digit_q;
    fsm_state_e    state_q;
    fsm_state_e    state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    key_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_key_debounce (
        .clk         (clk),
        .rst         (rst),
        .btn_raw_i   (bus.enter_btn),
        .pulse_o     (pulse),
        .pulse_next_o(pulse_next)
    );

    // Synchronize the switch digit and latch it as the strobe is raised, so
    // only its value at press acceptance matters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dsync1_q <= 4'd0;
            dsync2_q <= 4'd0;
            digit_q  <= 4'd0;
        end else begin
            dsync1_q <= bus.digit_in;
            dsync2_q <= dsync1_q;
            if (pulse_next) begin
                digit_q <= dsync2_q;
            end
        end
    end

    // Next state: advance on each accepted press while digits match; ERROR
    // ignores presses and leaves only through its hold timer.
    always_comb begin
        state_d = state_q;
        timer_d = '0;
        case (state_q)
            FSM_IDLE: begin
                if (pulse) begin
                    state_d = (digit_q == pw_nibble(PASSWORD, 2'd3)) ? FSM_DIGIT_2 : FSM_ERROR;
                end
            end
            FSM_DIGIT_2: begin
                if (pulse) begin
                    state_d = (digit_q == pw_nibble(PASSWORD, 2'd2)) ? FSM_DIGIT_3 : FSM_ERROR;
                end
            end
            FSM_DIGIT_3: begin
                if (pulse) begin
                    state_d = (digit_q == pw_nibble(PASSWORD, 2'd1)) ? FSM_DIGIT_4 : FSM_ERROR;
                end
            end
            FSM_DIGIT_4: begin
                if (pulse) begin
                    state_d = (digit_q == pw_nibble(PASSWORD, 2'd0)) ? FSM_DONE : FSM_ERROR;
                end
            end
            FSM_DONE: begin
                if (pulse) begin
                    state_d = FSM_IDLE;
                end
            end
            FSM_ERROR: begin
                if (timer_q >= ERR_LAST) begin
                    state_d = FSM_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = FSM_IDLE;
            end
        endcase
    end

    // State and error-timer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FSM_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    assign bus.state       = state_q;
    assign bus.enter_pulse = pulse;

endmodule

// File: tb/tb_password_fsm.sv
// Directed bench for password_fsm with short debounce and error-hold times.
module tb_password_fsm;

    localparam logic [15:0] PW  = 16'h2013;
    localparam int          DEB = 4;
    localparam int          ERR = 8;

    logic clk;
    logic rst;

    password_fsm_if bus ();

    password_fsm #(
        .PASSWORD  (PW),
        .DEB_CYCLES(DEB),
        .ERR_HOLD  (ERR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks;
    int         n_fail;
    int         t;
    int         npulse;
    int         first_pulse;
    logic       plog [0:63];
    logic [3:0] slog [0:63];

    // Per-cycle driver: apply inputs, let one rising edge pass, then log the
    // outputs at the falling edge. Index t = number of rising edges since mark.
    task automatic step(input logic btn, input logic [3:0] dig);
        bus.enter_btn = btn;
        bus.digit_in  = dig;
        @(posedge clk);
        @(negedge clk);
        if (t < 63) t = t + 1;
        plog[t] = bus.enter_pulse;
        slog[t] = bus.state;
        if (bus.enter_pulse) begin
            npulse = npulse + 1;
            if (first_pulse == 0) first_pulse = t;
        end
    endtask

    task automatic mark();
        t           = 0;
        npulse      = 0;
        first_pulse = 0;
    endtask

    // Clean press held for 'hold' cycles followed by a full release.
    task automatic press(input logic [3:0] dig, input int hold);
        mark();
        repeat (hold) step(1'b1, dig);
        repeat (8) step(1'b0, dig);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.enter_btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.enter_btn = 1'b0;
        bus.digit_in  = 4'd0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state);
        end
        n_checks++;
        if (bus.enter_pulse !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulse: got %0b expected 0", bus.enter_pulse);
        end
        rst = 1'b0;
        press(4'd2, 10);
        press(4'd0, 10);
        n_checks++;
        if (bus.state !== 4'd2) begin
            n_fail++; $display("FAIL reset_pre_digit3: got %0d expected 2", bus.state);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_fail++; $display("FAIL reset_async: got %0d expected 0", bus.state);
        end
        @(negedge clk);
        rst = 1'b0;
        press(4'd2, 10);
        n_checks++;
        if (bus.state !== 4'd1) begin
            n_fail++; $display("FAIL reset_restart_digit1: got %0d expected 1", bus.state);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] digs [0:3];
        logic [3:0] exps [0:3];
        digs = '{4'd2, 4'd0, 4'd1, 4'd3};
        exps = '{4'd1, 4'd2, 4'd3, 4'd4};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            press(digs[i], 10);
            n_checks++;
            if (npulse != 1) begin
                n_fail++; $display("FAIL seq_pulse_count[%0d]: got %0d expected 1", i, npulse);
            end
            n_checks++;
            if (first_pulse != 7) begin
                n_fail++; $display("FAIL seq_pulse_latency[%0d]: got %0d expected 7", i, first_pulse);
            end
            n_checks++;
            if (slog[8] !== exps[i] || bus.state !== exps[i]) begin
                n_fail++; $display("FAIL seq_state[%0d]: got %0d/%0d expected %0d", i, slog[8], bus.state, exps[i]);
            end
        end
        press(4'd5, 10);
        n_checks++;
        if (bus.state !== 4'd0) begin
            n_fail++; $display("FAIL seq_done_to_idle: got %0d expected 0", bus.state);
        end
    endtask

    task automatic test_error();
        int n_err;
        do_reset();
        press(4'd2, 10);
        mark();
        repeat (4) step(1'b1, 4'd7);
        repeat (4) step(1'b0, 4'd7);
        repeat (8) step(1'b1, 4'd2);
        repeat (8) step(1'b0, 4'd2);
        n_err = 0;
        for (int i = 1; i <= 24; i++) if (slog[i] === 4'd5) n_err++;
        n_checks++;
        if (slog[7] !== 4'd1) begin
            n_fail++; $display("FAIL err_before: got %0d expected 1", slog[7]);
        end
        n_checks++;
        if (plog[7] !== 1'b1 || plog[15] !== 1'b1 || npulse != 2) begin
            n_fail++; $display("FAIL err_pulses: got %0b/%0b/%0d expected 1/1/2", plog[7], plog[15], npulse);
        end
        n_checks++;
        if (slog[8] !== 4'd5 || slog[15] !== 4'd5) begin
            n_fail++; $display("FAIL err_state: got %0d/%0d expected 5/5", slog[8], slog[15]);
        end
        n_checks++;
        if (n_err != 8) begin
            n_fail++; $display("FAIL err_hold_len: got %0d expected 8", n_err);
        end
        n_checks++;
        if (slog[16] !== 4'd0 || bus.state !== 4'd0) begin
            n_fail++; $display("FAIL err_timeout: got %0d/%0d expected 0/0", slog[16], bus.state);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        mark();
        repeat (3) step(1'b1, 4'd2);
        repeat (3) step(1'b0, 4'd2);
        repeat (3) step(1'b1, 4'd2);
        repeat (10) step(1'b0, 4'd2);
        n_checks++;
        if (npulse != 0 || bus.state !== 4'd0) begin
            n_fail++; $display("FAIL glitch: got pulses %0d state %0d expected 0/0", npulse, bus.state);
        end
        mark();
        repeat (10) step(1'b1, 4'd2);
        step(1'b0, 4'd2);
        repeat (10) step(1'b1, 4'd2);
        repeat (8) step(1'b0, 4'd2);
        n_checks++;
        if (npulse != 1 || bus.state !== 4'd1) begin
            n_fail++; $display("FAIL dip: got pulses %0d state %0d expected 1/1", npulse, bus.state);
        end
    endtask

    task automatic test_digits();
        do_reset();
        press(4'hA, 10);
        n_checks++;
        if (slog[8] !== 4'd5 || bus.state !== 4'd0) begin
            n_fail++; $display("FAIL non_bcd: got %0d/%0d expected 5/0", slog[8], bus.state);
        end
        mark();
        repeat (4) step(1'b1, 4'd9);
        repeat (6) step(1'b1, 4'd2);
        repeat (8) step(1'b0, 4'd2);
        n_checks++;
        if (npulse != 1 || bus.state !== 4'd1) begin
            n_fail++; $display("FAIL digit_change: got pulses %0d state %0d expected 1/1", npulse, bus.state);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mark();
        repeat (30) step(1'b1, 4'd7);
        n_checks++;
        if (npulse != 1) begin
            n_fail++; $display("FAIL hold_refire: got pulses %0d expected 1", npulse);
        end
        n_checks++;
        if (slog[8] !== 4'd5 || slog[16] !== 4'd0 || slog[20] !== 4'd0 || slog[30] !== 4'd0) begin
            n_fail++; $display("FAIL hold_states: got %0d/%0d/%0d/%0d expected 5/0/0/0",
                               slog[8], slog[16], slog[20], slog[30]);
        end
        repeat (8) step(1'b0, 4'd7);
        press(4'd2, 10);
        n_checks++;
        if (npulse != 1 || bus.state !== 4'd1) begin
            n_fail++; $display("FAIL hold_new_press: got pulses %0d state %0d expected 1/1", npulse, bus.state);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mark();
        test_reset();
        test_sequence();
        test_error();
        test_glitch();
        test_digits();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
